wb_master_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 28 ++
 rtl/wb_arb_if.sv | 24 ++
 rtl/wb_arb_timeout.sv | 43 ++++
 rtl/wb_master_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_master_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_arb_pkg -- shared types and constants for wb_master_arbiter  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package wb_arb_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;

   localparam int M0 = 0;
   localparam int M1 = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]   addr;
      logic [DEF_DATA_W-1:0]   wdata;
      logic                    we;
      logic [DEF_DATA_W/8-1:0] sel;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_arb_if -- one Wishbone request/response link                 |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface wb_arb_if
   import wb_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;
   logic                we;
   logic [DATA_W/8-1:0] sel;
   logic                stb;
   logic                ack;
   logic                err;
   logic [DATA_W-1:0]   rdata;

   modport master (output addr, wdata, we, sel, stb, input ack, err, rdata);
   modport slave  (input addr, wdata, we, sel, stb, output ack, err, rdata);
endinterface
`default_nettype wire

// File: rtl/wb_arb_timeout.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_arb_timeout -- saturating busy-cycle counter with expire     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module wb_arb_timeout #(
   parameter int LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   generate
      if (LIMIT > 0) begin : g_count
         localparam int CW = $clog2(LIMIT + 1);
         localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

         logic [CW-1:0] r_count;

         // Holds at LAST rather than wrapping; the FSM leaves BUSY on that cycle.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_count <= '0;
            end else if (clear) begin
               r_count <= '0;
            end else if (enable && (r_count != LAST)) begin
               r_count <= r_count + 1'b1;
            end
         end

         assign expire = enable && (r_count == LAST);
      end else begin : g_off
         logic unused_inputs;
         assign unused_inputs = ^{clock, reset, clear, enable};
         assign expire        = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wb_master_arbiter -- 2-master round-robin Wishbone arbiter      |
// | with per-transaction timeout. Rev 1.0                           |
// +-----------------------------------------------------------------+
module wb_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clock,
   input  logic       reset,
   wb_arb_if.slave    m0,
   wb_arb_if.slave    m1,
   wb_arb_if.master   s,
   output logic [1:0] grant,
   output logic       busy
);

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [DATA_W-1:0]   wdata;
      logic                we;
      logic [DATA_W/8-1:0] sel;
   } req_t;

   arb_state_t               r_state;
   logic                     r_last;
   logic [1:0]               r_grant;
   logic                     r_busy;
   req_t                     r_req;
   logic                     r_stb;
   logic [1:0]               r_ack;
   logic [1:0]               r_err;
   logic [1:0][DATA_W-1:0]   r_rdata;

   req_t w_req0;
   req_t w_req1;
   logic w_any;
   logic w_pick;
   logic w_owner;
   logic w_expire;

   assign w_req0  = '{addr: m0.addr, wdata: m0.wdata, we: m0.we, sel: m0.sel};
   assign w_req1  = '{addr: m1.addr, wdata: m1.wdata, we: m1.we, sel: m1.sel};
   assign w_any   = m0.stb | m1.stb;
   // On a tie the master that did not finish last wins.
   assign w_pick  = (m0.stb & m1.stb) ? ~r_last : m1.stb;
   assign w_owner = r_grant[1];

   wb_arb_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (r_state != BUSY),
      .enable (r_state == BUSY),
      .expire (w_expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_last  <= 1'(M1);
         r_grant <= 2'b00;
         r_busy  <= 1'b0;
         r_req   <= '0;
         r_stb   <= 1'b0;
         r_ack   <= 2'b00;
         r_err   <= 2'b00;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_req   <= w_pick ? w_req1 : w_req0;
                  r_stb   <= 1'b1;
                  r_grant <= w_pick ? 2'b10 : 2'b01;
                  r_busy  <= 1'b1;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (s.ack) begin
                  r_stb            <= 1'b0;
                  r_rdata[w_owner] <= s.rdata;
                  r_ack[w_owner]   <= 1'b1;
                  r_last           <= w_owner;
                  r_state          <= DONE;
               end else if (w_expire) begin
                  r_stb            <= 1'b0;
                  r_rdata[w_owner] <= '0;
                  r_err[w_owner]   <= 1'b1;
                  r_last           <= w_owner;
                  r_state          <= DONE;
               end
            end
            DONE: begin
               r_ack   <= 2'b00;
               r_err   <= 2'b00;
               r_grant <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s.addr   = r_req.addr;
   assign s.wdata  = r_req.wdata;
   assign s.we     = r_req.we;
   assign s.sel    = r_req.sel;
   assign s.stb    = r_stb;

   assign m0.ack   = r_ack[M0];
   assign m1.ack   = r_ack[M1];
   assign m0.err   = r_err[M0];
   assign m1.err   = r_err[M1];
   assign m0.rdata = r_rdata[M0];
   assign m1.rdata = r_rdata[M1];

   assign grant    = r_grant;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_wb_master_arbiter -- directed self-checking bench            |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_wb_master_arbiter;

   logic       clock;
   logic       reset;
   logic [1:0] grant;
   logic       busy;

   int checks = 0;
   int errors = 0;

   wb_arb_if #(.ADDR_W(16), .DATA_W(32)) m0_if ();
   wb_arb_if #(.ADDR_W(16), .DATA_W(32)) m1_if ();
   wb_arb_if #(.ADDR_W(16), .DATA_W(32)) s_if ();

   wb_master_arbiter #(
      .ADDR_W         (16),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .m0    (m0_if),
      .m1    (m1_if),
      .s     (s_if),
      .grant (grant),
      .busy  (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed no finish, required finish before 50000");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      m0_if.addr = '0; m0_if.wdata = '0; m0_if.we = 1'b0; m0_if.sel = '0; m0_if.stb = 1'b0;
      m1_if.addr = '0; m1_if.wdata = '0; m1_if.we = 1'b0; m1_if.sel = '0; m1_if.stb = 1'b0;
      s_if.ack = 1'b0; s_if.rdata = '0; s_if.err = 1'b0;

      // Reset values
      #2 reset = 1'b1;
      step();
      step();
      check("rst_grant", grant, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_s_stb", s_if.stb, 1'b0);
      check("rst_m0_ack", m0_if.ack, 1'b0);
      check("rst_m0_rdata", m0_if.rdata, 32'h0);
      reset = 1'b0;

      // m0 write, slave acks two cycles after s_stb rises
      m0_if.addr = 16'h0010; m0_if.wdata = 32'hDEADBEEF; m0_if.we = 1'b1; m0_if.sel = 4'hF;
      m0_if.stb = 1'b1;
      step();
      check("w_s_stb", s_if.stb, 1'b1);
      check("w_s_addr", s_if.addr, 16'h0010);
      check("w_s_wdata", s_if.wdata, 32'hDEADBEEF);
      check("w_s_we", s_if.we, 1'b1);
      check("w_s_sel", s_if.sel, 4'hF);
      check("w_grant", grant, 2'b01);
      check("w_busy", busy, 1'b1);
      step();
      check("w_wait_ack", m0_if.ack, 1'b0);
      s_if.ack = 1'b1; s_if.rdata = 32'hCAFE0001;
      step();
      check("w_m0_ack", m0_if.ack, 1'b1);
      check("w_m1_ack", m1_if.ack, 1'b0);
      check("w_s_stb_low", s_if.stb, 1'b0);
      check("w_m0_rdata", m0_if.rdata, 32'hCAFE0001);
      s_if.ack = 1'b0; m0_if.stb = 1'b0;
      step();
      check("w_ack_pulse", m0_if.ack, 1'b0);
      check("w_idle_grant", grant, 2'b00);
      check("w_idle_busy", busy, 1'b0);

      // m1 read
      m1_if.addr = 16'h0020; m1_if.we = 1'b0; m1_if.sel = 4'hF; m1_if.stb = 1'b1;
      step();
      check("r_grant", grant, 2'b10);
      check("r_s_addr", s_if.addr, 16'h0020);
      check("r_s_we", s_if.we, 1'b0);
      s_if.ack = 1'b1; s_if.rdata = 32'h12345678;
      step();
      check("r_m1_ack", m1_if.ack, 1'b1);
      check("r_m0_ack", m0_if.ack, 1'b0);
      check("r_m1_rdata", m1_if.rdata, 32'h12345678);
      check("r_m0_rdata_hold", m0_if.rdata, 32'hCAFE0001);
      s_if.ack = 1'b0; m1_if.stb = 1'b0;
      step();

      // Timeout: 8 BUSY cycles with no ack
      m0_if.addr = 16'h0030; m0_if.we = 1'b0; m0_if.stb = 1'b1;
      step();
      repeat (7) step();
      check("to_no_err_yet", m0_if.err, 1'b0);
      check("to_stb_still", s_if.stb, 1'b1);
      step();
      check("to_m0_err", m0_if.err, 1'b1);
      check("to_m0_ack", m0_if.ack, 1'b0);
      check("to_m1_err", m1_if.err, 1'b0);
      check("to_s_stb", s_if.stb, 1'b0);
      check("to_m0_rdata", m0_if.rdata, 32'h0);
      m0_if.stb = 1'b0;
      step();
      check("to_err_pulse", m0_if.err, 1'b0);
      check("to_idle_grant", grant, 2'b00);

      // Ack on the 8th BUSY cycle wins over the timeout
      m0_if.stb = 1'b1;
      step();
      repeat (7) step();
      s_if.ack = 1'b1; s_if.rdata = 32'h55AA55AA;
      step();
      check("race_ack", m0_if.ack, 1'b1);
      check("race_err", m0_if.err, 1'b0);
      check("race_rdata", m0_if.rdata, 32'h55AA55AA);
      s_if.ack = 1'b0; m0_if.stb = 1'b0;
      step();

      // s_ack while idle, then owner drops stb mid-BUSY
      s_if.ack = 1'b1;
      step();
      check("idle_ack_m0", m0_if.ack, 1'b0);
      check("idle_ack_m1", m1_if.ack, 1'b0);
      check("idle_ack_busy", busy, 1'b0);
      s_if.ack = 1'b0;
      m0_if.addr = 16'h0040; m0_if.stb = 1'b1;
      step();
      m0_if.stb = 1'b0;
      step();
      check("drop_s_stb", s_if.stb, 1'b1);
      check("drop_s_addr", s_if.addr, 16'h0040);
      check("drop_grant", grant, 2'b01);
      s_if.ack = 1'b1; s_if.rdata = 32'hA5A5A5A5;
      step();
      check("drop_m0_ack", m0_if.ack, 1'b1);
      check("drop_m0_rdata", m0_if.rdata, 32'hA5A5A5A5);
      s_if.ack = 1'b0;
      step();

      // Reset mid-BUSY takes effect without a clock edge
      m1_if.stb = 1'b1;
      step();
      step();
      check("pre_rst_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("arst_s_stb", s_if.stb, 1'b0);
      check("arst_grant", grant, 2'b00);
      check("arst_busy", busy, 1'b0);
      m1_if.stb = 1'b0;
      step();
      reset = 1'b0;

      // Round-robin from reset: m0, m1, then m0 again
      m0_if.stb = 1'b1; m1_if.stb = 1'b1;
      step();
      check("rr1_grant", grant, 2'b01);
      s_if.ack = 1'b1;
      step();
      check("rr1_m0_ack", m0_if.ack, 1'b1);
      s_if.ack = 1'b0; m0_if.stb = 1'b0;
      step();
      step();
      check("rr2_grant", grant, 2'b10);
      s_if.ack = 1'b1;
      step();
      check("rr2_m1_ack", m1_if.ack, 1'b1);
      check("rr2_m0_ack", m0_if.ack, 1'b0);
      s_if.ack = 1'b0; m0_if.stb = 1'b1;
      step();
      check("rr_done_grant", grant, 2'b00);
      step();
      check("rr3_grant", grant, 2'b01);
      s_if.ack = 1'b1;
      step();
      s_if.ack = 1'b0; m0_if.stb = 1'b0; m1_if.stb = 1'b0;
      step();

      // m0 alone twice in a row keeps winning
      for (int i = 0; i < 2; i++) begin
         m0_if.stb = 1'b1;
         step();
         check("solo_grant", grant, 2'b01);
         s_if.ack = 1'b1;
         step();
         check("solo_m0_ack", m0_if.ack, 1'b1);
         s_if.ack = 1'b0; m0_if.stb = 1'b0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
